// File: rtl/hilo_muldiv_if.sv
// Pipeline-side signal bundle for the HI/LO multiply/divide unit.
// master = pipeline/EX control, slave = the arithmetic unit.
interface hilo_muldiv_if;
  // Handshake: op/src_a/src_b form the request and are held by the pipeline
  // while stallreq=1; a result is presented on any cycle with hi_we/lo_we=1
  // and is consumed on the first such cycle where stall_ex=0.
  logic        flush;
  logic        stall_ex;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output flush, stall_ex, op, src_a, src_b,
    input  stallreq, hi_we, lo_we, hi_o, lo_o
  );

  modport slave (
    input  flush, stall_ex, op, src_a, src_b,
    output stallreq, hi_we, lo_we, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv.sv
// EX-stage MULT/MULTU/DIV/DIVU/MTHI/MTLO unit: 1-cycle multiply stall,
// radix-2 restoring divide, HI/LO write-enables and data for the HI/LO block.
module hilo_muldiv #(
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [5:0] LAST_ITER = 6'(DIV_ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic        r_qneg;
  logic        r_rneg;
  logic [5:0]  r_cnt;

  state_t      w_next;
  logic        w_start_mul;
  logic        w_start_div;
  logic        w_stallreq;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  logic        w_is_div_s;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_prod;
  logic [31:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_next;

  assign w_is_div_s = (bus.op == OP_DIV);
  assign w_abs_a    = (w_is_div_s && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
  assign w_abs_b    = (w_is_div_s && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

  always_comb begin
    w_prod = '0;
    if (bus.op == OP_MULT)
      w_prod = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
    else
      w_prod = {32'd0, bus.src_a} * {32'd0, bus.src_b};
  end

  // The shifted-out rem bit means the partial remainder already exceeds any
  // 32-bit divisor; the 32-bit wraparound subtraction is then still exact.
  assign w_rem_sh   = {r_rem[30:0], r_quot[31]};
  assign w_ge       = r_rem[31] | (w_rem_sh >= r_divisor);
  assign w_rem_next = w_ge ? (w_rem_sh - r_divisor) : w_rem_sh;

  always_comb begin
    w_next      = r_state;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_stallreq  = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi        = '0;
    w_lo        = '0;
    if (!rst && !bus.flush) begin
      case (r_state)
        S_IDLE: begin
          case (bus.op)
            OP_MTHI: begin
              w_hi_we = 1'b1;
              w_hi    = bus.src_a;
            end
            OP_MTLO: begin
              w_lo_we = 1'b1;
              w_lo    = bus.src_a;
            end
            OP_MULT, OP_MULTU: begin
              w_stallreq  = 1'b1;
              w_start_mul = 1'b1;
              w_next      = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              w_stallreq  = 1'b1;
              w_start_div = 1'b1;
              w_next      = S_DIV;
            end
            default: ;
          endcase
        end
        S_MUL: begin
          w_hi_we      = 1'b1;
          w_lo_we      = 1'b1;
          {w_hi, w_lo} = r_prod;
          if (!bus.stall_ex) w_next = S_IDLE;
        end
        S_DIV: begin
          w_stallreq = 1'b1;
          if (r_cnt == LAST_ITER) w_next = S_DONE;
        end
        S_DONE: begin
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_lo    = r_qneg ? (~r_quot + 32'd1) : r_quot;
          w_hi    = r_rneg ? (~r_rem + 32'd1) : r_rem;
          if (!bus.stall_ex) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state   <= S_IDLE;
      r_prod    <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_mul) r_prod <= w_prod;
      if (w_start_div) begin
        r_rem     <= '0;
        r_quot    <= w_abs_a;
        r_divisor <= w_abs_b;
        r_qneg    <= w_is_div_s & (bus.src_a[31] ^ bus.src_b[31]);
        r_rneg    <= w_is_div_s & bus.src_a[31];
        r_cnt     <= '0;
      end else if (r_state == S_DIV) begin
        r_rem  <= w_rem_next;
        r_quot <= {r_quot[30:0], w_ge};
        r_cnt  <= r_cnt + 6'd1;
      end
    end
  end

  assign bus.stallreq = w_stallreq;
  assign bus.hi_we    = w_hi_we;
  assign bus.lo_we    = w_lo_we;
  assign bus.hi_o     = w_hi;
  assign bus.lo_o     = w_lo;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed test-plan cases plus random
// ops checked against an arithmetic reference model.
module tb_hilo_muldiv;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_if bus ();

  hilo_muldiv #(.DIV_ITER(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: results straight from signed/unsigned integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic hwe, output logic lwe, output int stalls);
    longint sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0; hwe = 1'b0; lwe = 1'b0; stalls = 0;
    case (op)
      OP_MTHI: begin hi = a; hwe = 1'b1; end
      OP_MTLO: begin lo = a; lwe = 1'b1; end
      OP_MULT: begin
        sp = sa * sb;
        {hi, lo} = 64'(sp);
        hwe = 1'b1; lwe = 1'b1; stalls = 1;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {hi, lo} = up;
        hwe = 1'b1; lwe = 1'b1; stalls = 1;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          lo = a[31] ? 32'd1 : 32'hFFFFFFFF;
          hi = a;
        end else begin
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
        hwe = 1'b1; lwe = 1'b1; stalls = 33;
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          lo = 32'hFFFFFFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
        hwe = 1'b1; lwe = 1'b1; stalls = 33;
      end
      default: ;
    endcase
  endtask

  task automatic drive_idle();
    bus.op = OP_NONE; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.stall_ex = 1'b0;
  endtask

  // Issue one op, count stall cycles, check the result, optionally hold with stall_ex.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [31:0] hi, output logic [31:0] lo);
    logic [31:0] e_hi, e_lo;
    logic        e_hwe, e_lwe;
    int          e_stall, n;
    logic [63:0] exp;
    model(op, a, b, e_hi, e_lo, e_hwe, e_lwe, e_stall);
    exp_q.push_back({e_hi, e_lo});
    @(negedge clk);
    bus.op = op; bus.src_a = a; bus.src_b = b;
    #1;
    n = 0;
    while (bus.stallreq === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    exp = exp_q.pop_front();
    check("stall_cycles", 64'(n), 64'(e_stall));
    check("we", 64'({bus.hi_we, bus.lo_we}), 64'({e_hwe, e_lwe}));
    check("result", {bus.hi_o, bus.lo_o}, exp);
    hi = bus.hi_o; lo = bus.lo_o;
    if (hold > 0) begin
      bus.stall_ex = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        check("hold_stallreq", 64'(bus.stallreq), 64'(0));
        check("hold_we", 64'({bus.hi_we, bus.lo_we}), 64'({e_hwe, e_lwe}));
        check("hold_result", {bus.hi_o, bus.lo_o}, exp);
      end
      bus.stall_ex = 1'b0;
    end
  endtask

  logic [31:0] r_hi, r_lo;

  initial begin
    // reset
    rst = 1'b1;
    drive_idle();
    bus.op = OP_MULT; bus.src_a = 32'h5; bus.src_b = 32'h7;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {27'd0, bus.stallreq, bus.hi_we, bus.lo_we, dbg_state}, 64'd0);
    check("reset_data", {bus.hi_o, bus.lo_o}, 64'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    // MTHI / MTLO
    run_op(OP_MTHI, 32'h12345678, 32'h0, 0, r_hi, r_lo);
    check("mthi_hi", 64'(r_hi), 64'h12345678);
    run_op(OP_MTLO, 32'h12345678, 32'h0, 0, r_hi, r_lo);
    check("mtlo_lo", 64'(r_lo), 64'h12345678);

    // multiply
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h2, 0, r_hi, r_lo);
    check("mult_const", {r_hi, r_lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 0, r_hi, r_lo);
    check("multu_const", {r_hi, r_lo}, 64'h00000001_FFFFFFFE);

    // divide
    run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, 0, r_hi, r_lo);
    check("div_m7_2", {r_hi, r_lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, r_hi, r_lo);
    check("divu_100_7", {r_hi, r_lo}, {32'd2, 32'd14});
    run_op(OP_DIVU, 32'd5, 32'd0, 0, r_hi, r_lo);
    check("divu_by_zero", {r_hi, r_lo}, {32'd5, 32'hFFFFFFFF});
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, r_hi, r_lo);
    check("div_min_m1", {r_hi, r_lo}, {32'd0, 32'h80000000});

    // flush mid-divide at iteration 10
    @(negedge clk);
    bus.op = OP_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_comb_stall", 64'(bus.stallreq), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0; bus.op = OP_NONE;
    #1;
    check("flush_state", 64'(dbg_state), 64'(0));
    check("flush_outputs", {61'd0, bus.stallreq, bus.hi_we, bus.lo_we}, 64'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 0, r_hi, r_lo);
    check("divu_after_flush", {r_hi, r_lo}, {32'd0, 32'd3});

    // flush in IDLE prevents a start
    @(negedge clk);
    bus.op = OP_MULT; bus.src_a = 32'd3; bus.src_b = 32'd4; bus.flush = 1'b1;
    #1;
    check("flush_idle_stall", 64'(bus.stallreq), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0; bus.op = OP_NONE;
    #1;
    check("flush_idle_state", 64'(dbg_state), 64'(0));

    // DONE held by stall_ex, then immediate new op
    run_op(OP_DIV, 32'd50, 32'hFFFFFFF9, 3, r_hi, r_lo);
    run_op(OP_MULTU, 32'd6, 32'd7, 2, r_hi, r_lo);
    check("mul_after_hold", {r_hi, r_lo}, 64'd42);

    // reset mid-divide
    @(negedge clk);
    bus.op = OP_DIVU; bus.src_a = 32'd77; bus.src_b = 32'd5;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_comb", {61'd0, bus.stallreq, bus.hi_we, bus.lo_we}, 64'd0);
    @(negedge clk);
    #1;
    check("rst_mid_state", {30'd0, dbg_state, bus.hi_o}, 64'd0);
    check("rst_mid_lo", 64'(bus.lo_o), 64'd0);
    rst = 1'b0;
    drive_idle();

    // random ops
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = {a[31], 31'($urandom_range(0, 20))};
      run_op(op, a, b, $urandom_range(0, 2), r_hi, r_lo);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
